flip_flop_fifo_valid_ready_counted: RTL
=======================================

Name: flip_flop_fifo_valid_ready_counted

Overview:
Parametrised flip-flop FIFO with valid/ready handshakes on both sides, replacing the push/pop/empty/full flavour in the fifo_valid_ready postprocess path. Adds an occupancy count, almost-full and almost-empty flags, a synchronous flush, and an optional registered output stage for timing closure. Depth is arbitrary (≥2) and need not be a power of two; pointers wrap at depth-1 and use an odd-circle bit.

Parameters:
width, 8, data width in bits
depth, 10, total capacity in entries (≥2), including the output register when output_reg=1
almost_full_level, depth-2, almost_full asserted when count ≥ this value (1..depth)
almost_empty_level, 2, almost_empty asserted when count ≤ this value (0..depth-1)
output_reg, 0, 0 = down_data read combinationally from the array; 1 = down_data/down_valid come from a prefetch flop stage

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of contents; wins over all transfers
up_valid  input  1  upstream data valid
up_ready  output  1  FIFO can accept; = !full & !flush
up_data  input  width  write data
down_valid  output  1  FIFO has data for downstream; forced 0 while flush=1
down_ready  input  1  downstream accepts
down_data  output  width  read data; undefined when down_valid=0
count  output  $clog2(depth+1)  entries held, including the output register
almost_full  output  1  count ≥ almost_full_level
almost_empty  output  1  count ≤ almost_empty_level

Behaviour:
- Reset (async, rst=1): pointers, odd-circle bits, count, output-register valid = 0. Outputs: up_ready=1, down_valid=0, count=0, almost_empty=1, almost_full=0 (unless almost_full_level=0, which is illegal). Array contents are not reset.
- Transfers: push = up_valid & up_ready; pop = down_valid & down_ready. up_ready never depends on down_ready; when full, a same-cycle pop does not allow a push.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Saturation is impossible by construction. A verification assertion must check 0 ≤ count ≤ depth.
- Flags are derived combinationally from registered count only. There is no path from up_valid or down_ready to any flag.
- output_reg=0:
  - Array holds depth entries. down_valid = !empty. down_data = array[rd_ptr].
  - Latency: a push at edge N is visible with down_valid=1 after edge N. No same-cycle fall-through.
  - full/empty use the equal-pointer plus odd-circle comparison.
- output_reg=1:
  - Array holds depth-1 entries, plus one output register (ovalid, odata).
  - Load rule: at each edge, if (!ovalid | pop) and the array is non-empty, move array[rd_ptr] into odata and set ovalid=1. Otherwise, if pop, clear ovalid.
  - down_valid = ovalid; down_data = odata.
  - Latency: a push at edge N into an empty FIFO appears on down_valid after edge N+1; count=1 already after edge N.
  - full = array full & ovalid.
- Wrap-around: each pointer goes depth_arr-1 → 0 and toggles its odd-circle bit, where depth_arr = depth (mode 0) or depth-1 (mode 1).
- Flush:
  - On an edge with flush=1: pointers, odd bits, count and ovalid are cleared.
  - Any push or pop that cycle is ignored, since up_ready and down_valid are held 0.
  - Next cycle the FIFO behaves as after reset.
- Reset mid-operation: immediate asynchronous clear. The first legal push comes on the first edge after rst deasserts.

Test Plan:
- depth=4, mode 0: push 0xA1..0xA4 with down_ready=0 → count 1,2,3,4; almost_full at count 2 (level 2); up_ready=0 at count 4; a 5th up_valid is not accepted.
- Same config, full: down_ready=1, up_valid=1 for one cycle → pop only, count 4→3; next cycle push+pop → count stays 3; output order A1,A2,A3,A4,new with no loss.
- depth=5 (non-power-of-2), mode 0: stream 20 words 0x00..0x13 with random valid/ready → output identical sequence; pointers wrap ≥3 times; count never exceeds 5.
- depth=4, mode 1: push 0x55 into empty FIFO at edge N → count=1 after N, down_valid=1 only after N+1, data 0x55; fill to 4 → up_ready=0 at count 4 (3 array + 1 register).
- Flush with count=3 and up_valid=down_ready=1 → after the edge count=0, down_valid=0, almost_empty=1; the word offered during the flush cycle is not stored.
- Assert rst asynchronously mid-burst (count=2, between edges) → count=0, down_valid=0, up_ready=1 immediately; after deassertion, push 0x7E → read back 0x7E.

Source files
------------

// File: rtl/flip_flop_fifo_valid_ready_counted.sv
// Flip-flop FIFO with valid/ready handshakes on both sides, an occupancy count,
// almost-full/almost-empty flags, a synchronous flush and an optional registered
// output stage.
//
// Parameters:
//   width              data width in bits
//   depth              total capacity in entries (>= 2), output register included
//   almost_full_level  almost_full when count >= this value (1..depth)
//   almost_empty_level almost_empty when count <= this value (0..depth-1)
//   output_reg         0: down_data read straight from the array
//                      1: down_valid/down_data come from a prefetch flop stage
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous clear of contents; overrides all transfers
//   up_valid/up_ready   upstream handshake, up_data is the write data
//   down_valid/down_ready downstream handshake, down_data is the read data
//   count               entries held, output register included
//   almost_full/almost_empty  flags decoded from the registered count
module flip_flop_fifo_valid_ready_counted #(
    parameter int unsigned width              = 8,
    parameter int unsigned depth              = 10,
    parameter int unsigned almost_full_level  = depth - 2,
    parameter int unsigned almost_empty_level = 2,
    parameter bit          output_reg         = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [width-1:0]           up_data,
    output logic                       down_valid,
    input  logic                       down_ready,
    output logic [width-1:0]           down_data,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty
);

    // With the output stage, one of the depth entries lives in the output flop.
    localparam int unsigned depth_arr = output_reg ? depth - 1 : depth;
    localparam int unsigned ptr_w     = (depth_arr > 1) ? $clog2(depth_arr) : 1;
    localparam int unsigned cnt_w     = $clog2(depth + 1);

    typedef logic [ptr_w-1:0] ptr_t;
    localparam ptr_t ptr_last = ptr_t'(depth_arr - 1);

    logic [width-1:0] mem_q [depth_arr];

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic             wr_odd_q, wr_odd_d;
    logic             rd_odd_q, rd_odd_d;
    logic [cnt_w-1:0] count_q, count_d;

    logic arr_empty;
    logic arr_full;
    logic full;
    logic push;
    logic pop;
    logic arr_pop;

    // Equal pointers: same lap means empty, different lap means full.
    assign arr_empty = (wr_ptr_q == rd_ptr_q) && (wr_odd_q == rd_odd_q);
    assign arr_full  = (wr_ptr_q == rd_ptr_q) && (wr_odd_q != rd_odd_q);

    generate
        if (output_reg) begin : g_out_reg
            logic             ovalid_q;
            logic [width-1:0] odata_q;

            // An array-full/ovalid=0 state only exists while that entry is
            // being moved into the output flop, so a push that cycle is safe.
            assign full       = arr_full & ovalid_q;
            assign down_valid = ovalid_q & ~flush;
            assign down_data  = odata_q;
            assign arr_pop    = (~ovalid_q | pop) & ~arr_empty & ~flush;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovalid_q <= 1'b0;
                end else if (flush) begin
                    ovalid_q <= 1'b0;
                end else if (arr_pop) begin
                    ovalid_q <= 1'b1;
                end else if (pop) begin
                    ovalid_q <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (arr_pop) begin
                    odata_q <= mem_q[rd_ptr_q];
                end
            end
        end else begin : g_no_out_reg
            assign full       = arr_full;
            assign down_valid = ~arr_empty & ~flush;
            assign down_data  = mem_q[rd_ptr_q];
            assign arr_pop    = pop;
        end
    endgenerate

    // up_ready deliberately ignores down_ready: no push into a full FIFO even
    // when a pop happens in the same cycle.
    assign up_ready = ~full & ~flush;
    assign push     = up_valid & up_ready;
    assign pop      = down_valid & down_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_odd_d = wr_odd_q;
        rd_ptr_d = rd_ptr_q;
        rd_odd_d = rd_odd_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            wr_odd_d = 1'b0;
            rd_ptr_d = '0;
            rd_odd_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push) begin
                if (wr_ptr_q == ptr_last) begin
                    wr_ptr_d = '0;
                    wr_odd_d = ~wr_odd_q;
                end else begin
                    wr_ptr_d = wr_ptr_q + ptr_t'(1);
                end
            end
            if (arr_pop) begin
                if (rd_ptr_q == ptr_last) begin
                    rd_ptr_d = '0;
                    rd_odd_d = ~rd_odd_q;
                end else begin
                    rd_ptr_d = rd_ptr_q + ptr_t'(1);
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + cnt_w'(1);
                2'b01:   count_d = count_q - cnt_w'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            wr_odd_q <= 1'b0;
            rd_ptr_q <= '0;
            rd_odd_q <= 1'b0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            wr_odd_q <= wr_odd_d;
            rd_ptr_q <= rd_ptr_d;
            rd_odd_q <= rd_odd_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= up_data;
        end
    end

    assign count        = count_q;
    assign almost_full  = (count_q >= cnt_w'(almost_full_level));
    assign almost_empty = (count_q <= cnt_w'(almost_empty_level));

    // count is unsigned, so only the upper bound needs checking.
    count_in_range: assert property (@(posedge clk) disable iff (rst)
        count_q <= cnt_w'(depth));

endmodule
